// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared types and constants for the general-purpose register file.
//   reg_addr_t  : 5-bit register index
//   uint32_t    : 32-bit register word
//   reg_wreq_t  : write-back request {we, waddr, wrdata}
//   REG_NUM     : number of architectural registers
//   REG_ZERO    : index of the hardwired-zero register
// ----------------------------------------------------------------------------
package regfile_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] uint32_t;

    typedef struct packed {
        logic      we;
        reg_addr_t waddr;
        uint32_t   wrdata;
    } reg_wreq_t;

    localparam int        REG_NUM  = 32;
    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : regfile_pkg

// File: rtl/regfile_wsel.sv
// ----------------------------------------------------------------------------
// regfile_wsel
// Combinational priority selector: reports whether any write request targets
// `addr` and returns the data of the highest-index matching request.
// Ports:
//   addr  in  reg_addr_t                    address to match
//   wreq  in  reg_wreq_t[WRITE_PORT-1:0]    write-request vector
//   hit   out logic                         some enabled request matches
//   data  out uint32_t                      wrdata of highest matching port
// ----------------------------------------------------------------------------
module regfile_wsel
    import regfile_pkg::*;
#(
    parameter int WRITE_PORT = 1
) (
    input  reg_addr_t                   addr,
    input  reg_wreq_t [WRITE_PORT-1:0]  wreq,
    output logic                        hit,
    output uint32_t                     data
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan: a later (higher-index) match overrides earlier ones.
        for (int j = 0; j < WRITE_PORT; j++) begin
            if (wreq[j].we && (wreq[j].waddr == addr)) begin
                hit  = 1'b1;
                data = wreq[j].wrdata;
            end
        end
    end

endmodule : regfile_wsel

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
// 32 x 32-bit MIPS register file with combinational read ports, synchronous
// write ports and same-cycle write-through bypass. Register 0 reads as zero.
// Ports:
//   clk          in  1                           core clock, rising edge
//   rst_n        in  1                           synchronous active-low reset
//   regs_wreq    in  reg_wreq_t[WRITE_PORT-1:0]  write-back requests
//   regs_raddr   in  reg_addr_t[READ_PORT-1:0]   decode read addresses
//   regs_rddata  out uint32_t[READ_PORT-1:0]     read data to forwarding
// ----------------------------------------------------------------------------
module regfile
    import regfile_pkg::*;
#(
    parameter int READ_PORT  = 2,
    parameter int WRITE_PORT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  reg_wreq_t [WRITE_PORT-1:0]  regs_wreq,
    input  reg_addr_t [READ_PORT-1:0]   regs_raddr,
    output uint32_t   [READ_PORT-1:0]   regs_rddata
);

    uint32_t regs_q [REG_NUM];
    uint32_t regs_d [REG_NUM];

    // Per-entry write selection; entry 0 never takes writes so it has none.
    logic    wr_hit  [1:REG_NUM-1];
    uint32_t wr_data [1:REG_NUM-1];

    // Per-read-port bypass selection, same priority logic as the update path.
    logic    byp_hit  [READ_PORT];
    uint32_t byp_data [READ_PORT];

    for (genvar k = 1; k < REG_NUM; k++) begin : g_entry
        regfile_wsel #(
            .WRITE_PORT (WRITE_PORT)
        ) u_wsel (
            .addr (reg_addr_t'(k)),
            .wreq (regs_wreq),
            .hit  (wr_hit[k]),
            .data (wr_data[k])
        );
    end

    for (genvar i = 0; i < READ_PORT; i++) begin : g_rd
        regfile_wsel #(
            .WRITE_PORT (WRITE_PORT)
        ) u_wsel (
            .addr (regs_raddr[i]),
            .wreq (regs_wreq),
            .hit  (byp_hit[i]),
            .data (byp_data[i])
        );
    end

    always_comb begin
        regs_d[0] = '0;
        for (int k = 1; k < REG_NUM; k++) begin
            regs_d[k] = wr_hit[k] ? wr_data[k] : regs_q[k];
        end
    end

    // NOTE: the reset clears the whole array because reset contents are
    // architecturally visible here; this rules out mapping onto a RAM macro.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_NUM; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < REG_NUM; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Bypass is gated by rst_n: a write presented during reset never lands,
    // so it must not be visible either.
    always_comb begin
        for (int i = 0; i < READ_PORT; i++) begin
            if (regs_raddr[i] == REG_ZERO) begin
                regs_rddata[i] = '0;
            end else if (rst_n && byp_hit[i]) begin
                regs_rddata[i] = byp_data[i];
            end else begin
                regs_rddata[i] = regs_q[regs_raddr[i]];
            end
        end
    end

endmodule : regfile

// File: doc/regfile.md
# regfile

General-purpose register file of the MIPS core: 32 × 32-bit registers with `READ_PORT` combinational read ports and `WRITE_PORT` synchronous write ports. It sits directly upstream of the decode-stage forwarding network and feeds that network its `regs_rddata_i`, and it is written by the write-back stage. Writes landing in the same cycle are bypassed to the read ports, so decode sees write-back results without a stall; the forwarding stage then only has to cover the execute stage.

## Interface
Parameters:
- `READ_PORT`, 2, number of independent read ports.
- `WRITE_PORT`, 1, number of write ports; higher index has higher priority.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `regs_wreq`  in  `reg_wreq_t[WRITE_PORT-1:0]`  write requests from write-back; each has `we`, `waddr` (`reg_addr_t`), `wrdata` (`uint32_t`).
- `regs_raddr`  in  `reg_addr_t[READ_PORT-1:0]`  read addresses from decode.
- `regs_rddata`  out  `uint32_t[READ_PORT-1:0]`  read data to the decode forwarding stage.

## Operation
- Storage is 32 entries of `uint32_t`, indexed by the 5-bit `reg_addr_t`. Register 0 is hardwired to 0:
  - writes to address 0 are discarded;
  - reads of address 0 return 0, regardless of storage contents or any bypass.
- Write, at the rising edge with `rst_n`=1: for each entry k ≠ 0, if any port j has `we`=1 and `waddr`=k, then entry k takes `wrdata` of the highest such j.
- Read is combinational. For each port i:
  - if `regs_raddr[i]`=0, output 0;
  - else if `rst_n`=1 and some port j has `we`=1 and `waddr`=`regs_raddr[i]`, output that `wrdata` from the highest such j (write-through bypass);
  - else output the stored entry.
- Read ports are fully independent. Any number of ports may read the same address.
- Reset: on a rising edge with `rst_n`=0, all 32 entries clear to 0. Write requests in that cycle are ignored. The bypass is disabled while `rst_n`=0.

## Timing
- Read latency is 0 cycles (combinational from `regs_raddr`/`regs_wreq` to `regs_rddata`).
- A write is visible on the read ports in its own cycle via the bypass, and from storage from the next cycle on.
- Reset value of `regs_rddata`:
  - all zero from the first cycle after a reset edge;
  - before the first reset edge, contents are undefined except for address 0.
- Reset mid-operation: entries written in earlier cycles are lost. A write presented in the same cycle as `rst_n`=0 never lands.
- Simultaneous write and read of the same address:
  - the read returns the new data;
  - after the edge, storage holds the same value (no read/write mismatch).
- Multiple ports writing the same address: only the highest-index port's data is stored and bypassed. Lower-index data is never observable.
- No handshakes and no back-pressure. The block accepts a write every cycle on every port.

## Structure
- Shared package / `inst_decode.svh` holds:
  - `reg_addr_t` (`logic [4:0]`);
  - `uint32_t`;
  - `reg_wreq_t` (`we`, `waddr`, `wrdata`), the same struct used inside `pipe_ex_t`;
  - constant `REG_NUM` = 32;
  - constant `REG_ZERO` = 5'd0.
- One sub-module is natural: `regfile_wsel`. It is a purely combinational priority selector that, given an address and the write-request vector, returns hit/data for the highest-index matching port. It is instantiated once per entry for the update path and once per read port for the bypass, so both paths share identical priority.

## Test plan
- Reset then read: hold `rst_n`=0 for 2 cycles, release, read addresses 1, 17 and 31 on both ports -> all return 0x00000000.
- Write then read: write 0xDEADBEEF to r5 in cycle N, read r5 in cycle N+1 -> 0xDEADBEEF; r6 is still 0.
- Same-cycle bypass: with `WRITE_PORT`=1, write 0x12345678 to r9 while port 0 reads r9 and port 1 reads r8 -> port 0 = 0x12345678, port 1 = old r8. The next cycle r9 reads 0x12345678 from storage.
- Zero register: write 0xFFFFFFFF to r0, read r0 in the same cycle and the next cycle -> 0 both times.
- Port conflict: with `WRITE_PORT`=2, port 0 writes 0xAAAA0000 to r3 and port 1 writes 0x5555FFFF to r3 in the same cycle. Same-cycle read -> 0x5555FFFF; next-cycle read -> 0x5555FFFF.
- Reset mid-run:
  - step 1: load r1 with 0x1 and r2 with 0x2;
  - step 2: assert `rst_n`=0 for one cycle while also requesting a write of 0x77 to r4. During that cycle r4 reads the old value with no bypass;
  - step 3: after release, r1, r2 and r4 all read 0.
